// File: rtl/flash_page_writer.sv
// rtl/flash_page_writer.sv - SPI NOR page program sequencer: WREN, PP with address/data, RDSR poll until WIP clears.
module flash_page_writer #(
  parameter int          MAXBYTES      = 1,
  parameter int          SLOWDOWN_BITS = 3,
  parameter logic [15:0] POLL_LIMIT    = 16'd8191
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [23:0]             address,
  input  logic [8*MAXBYTES-1:0]   data,
  input  logic                    Q,
  output logic                    NCS,
  output logic                    D,
  output logic                    clk_out,
  output logic                    busy,
  output logic                    done,
  output logic                    error
);

  localparam int          DBITS     = 8 * MAXBYTES;
  localparam int          W         = 32 + DBITS;
  localparam logic [10:0] DATA_LAST = 11'(DBITS - 1);

  localparam logic [7:0] CMD_WREN = 8'h06;
  localparam logic [7:0] CMD_PP   = 8'h02;
  localparam logic [7:0] CMD_RDSR = 8'h05;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] WREN   = 3'd1;
  localparam logic [2:0] GAP1   = 3'd2;
  localparam logic [2:0] PROG   = 3'd3;
  localparam logic [2:0] GAP2   = 3'd4;
  localparam logic [2:0] POLL   = 3'd5;
  localparam logic [2:0] FINISH = 3'd6;

  logic [SLOWDOWN_BITS-1:0] div_q;
  logic                     phase_q;
  logic [2:0]               state_q, state_d;
  logic [10:0]              bit_q, bit_d;
  logic [15:0]              poll_q, poll_d;
  logic                     wip_q, wip_d;
  logic [W-1:0]             sr_q, sr_d;
  logic [23:0]              addr_q, addr_d;
  logic [DBITS-1:0]         data_q, data_d;
  logic                     data_ph_q, data_ph_d;
  logic                     pending_q, pending_d;
  logic                     error_q, error_d;
  logic                     start_prev_q;

  logic                     tick, rise, fall, accept, ncs_low;
  logic [W-1:0]             sr_shift;
  logic [15:0]              poll_inc;

  // Every state change lands on a falling phase tick, so each NCS-low frame opens with clk_out low.
  assign tick     = &div_q;
  assign rise     = tick & ~phase_q;
  assign fall     = tick & phase_q;
  assign accept   = start & ~start_prev_q & (state_q == IDLE) & ~pending_q;
  assign sr_shift = {sr_q[W-2:0], 1'b0};
  assign poll_inc = poll_q + 16'd1;

  always_comb begin
    state_d   = state_q;
    bit_d     = bit_q;
    poll_d    = poll_q;
    wip_d     = wip_q;
    sr_d      = sr_q;
    addr_d    = addr_q;
    data_d    = data_q;
    data_ph_d = data_ph_q;
    pending_d = pending_q;
    error_d   = error_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          pending_d = 1'b1;
          addr_d    = address;
          data_d    = data;
          error_d   = 1'b0;
        end else if (pending_q && fall) begin
          pending_d = 1'b0;
          state_d   = WREN;
          bit_d     = 11'd0;
          sr_d      = {CMD_WREN, {(W-8){1'b0}}};
        end
      end
      WREN: begin
        if (fall) begin
          sr_d = sr_shift;
          if (bit_q == 11'd7) begin
            state_d = GAP1;
            bit_d   = 11'd0;
          end else begin
            bit_d = bit_q + 11'd1;
          end
        end
      end
      GAP1: begin
        if (fall) begin
          if (bit_q == 11'd1) begin
            state_d   = PROG;
            bit_d     = 11'd0;
            data_ph_d = 1'b0;
            sr_d      = {CMD_PP, addr_q, data_q};
          end else begin
            bit_d = bit_q + 11'd1;
          end
        end
      end
      PROG: begin
        // Header and payload are counted separately so 256 data bytes never overflow the 11-bit counter.
        if (fall) begin
          sr_d = sr_shift;
          if (!data_ph_q && bit_q == 11'd31) begin
            data_ph_d = 1'b1;
            bit_d     = 11'd0;
          end else if (data_ph_q && bit_q == DATA_LAST) begin
            state_d   = GAP2;
            bit_d     = 11'd0;
            data_ph_d = 1'b0;
          end else begin
            bit_d = bit_q + 11'd1;
          end
        end
      end
      GAP2: begin
        if (fall) begin
          if (bit_q == 11'd1) begin
            state_d = POLL;
            bit_d   = 11'd0;
            poll_d  = 16'd0;
            sr_d    = {CMD_RDSR, {(W-8){1'b0}}};
          end else begin
            bit_d = bit_q + 11'd1;
          end
        end
      end
      POLL: begin
        // Status arrives MSB first, so the last sample of each byte is WIP.
        if (rise) wip_d = Q;
        if (fall) begin
          sr_d = sr_shift;
          if (bit_q == 11'd15) begin
            bit_d = 11'd8;
            if (!wip_q) begin
              state_d = FINISH;
            end else if (poll_inc >= POLL_LIMIT) begin
              poll_d  = poll_inc;
              error_d = 1'b1;
              state_d = FINISH;
            end else begin
              poll_d = poll_inc;
            end
          end else begin
            bit_d = bit_q + 11'd1;
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
        bit_d   = 11'd0;
        poll_d  = 16'd0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q        <= '0;
      phase_q      <= 1'b0;
      state_q      <= IDLE;
      bit_q        <= 11'd0;
      poll_q       <= 16'd0;
      wip_q        <= 1'b0;
      sr_q         <= '0;
      addr_q       <= 24'd0;
      data_q       <= '0;
      data_ph_q    <= 1'b0;
      pending_q    <= 1'b0;
      error_q      <= 1'b0;
      start_prev_q <= 1'b1;
    end else begin
      div_q        <= div_q + 1'b1;
      phase_q      <= phase_q ^ tick;
      state_q      <= state_d;
      bit_q        <= bit_d;
      poll_q       <= poll_d;
      wip_q        <= wip_d;
      sr_q         <= sr_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      data_ph_q    <= data_ph_d;
      pending_q    <= pending_d;
      error_q      <= error_d;
      start_prev_q <= start;
    end
  end

  // D and clk_out float while deselected so another master can own the bus.
  assign ncs_low = (state_q == WREN) || (state_q == PROG) || (state_q == POLL);
  assign NCS     = ~ncs_low;
  assign D       = ncs_low ? sr_q[W-1] : 1'bz;
  assign clk_out = ncs_low ? phase_q : 1'bz;
  assign busy    = pending_q || ((state_q != IDLE) && (state_q != FINISH));
  assign done    = (state_q == FINISH);
  assign error   = error_q;

endmodule

// File: tb/tb_flash_page_writer.sv
// tb/tb_flash_page_writer.sv - bench for flash_page_writer with a bit-level SPI flash model and frame scoreboard.
module tb_flash_page_writer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start1 = 1'b0, start4 = 1'b0;
  logic [23:0] addr_in = 24'd0;
  logic [7:0]  data1 = 8'd0;
  logic [31:0] data4 = 32'd0;
  logic        q_drv = 1'b0;
  wire         ncs1, d1, co1, busy1, done1, err1;
  wire         ncs4, d4, co4, busy4, done4, err4;

  always #5 clk = ~clk;

  flash_page_writer #(.MAXBYTES(1), .SLOWDOWN_BITS(3)) u1 (
    .clk(clk), .reset(reset), .start(start1), .address(addr_in), .data(data1), .Q(q_drv),
    .NCS(ncs1), .D(d1), .clk_out(co1), .busy(busy1), .done(done1), .error(err1));

  flash_page_writer #(.MAXBYTES(4), .SLOWDOWN_BITS(3), .POLL_LIMIT(16'd4)) u4 (
    .clk(clk), .reset(reset), .start(start4), .address(addr_in), .data(data4), .Q(q_drv),
    .NCS(ncs4), .D(d4), .clk_out(co4), .busy(busy4), .done(done4), .error(err4));

  logic sel = 1'b0;
  wire  ncs_s  = sel ? ncs4  : ncs1;
  wire  d_s    = sel ? d4    : d1;
  wire  co_s   = sel ? co4   : co1;
  wire  busy_s = sel ? busy4 : busy1;
  wire  done_s = sel ? done4 : done1;
  wire  err_s  = sel ? err4  : err1;

  int tests = 0, fails = 0;

  // Flash model knobs: number of leading WIP=1 status bytes, or stuck busy forever.
  int wip_n = 0;
  bit stuck = 1'b0;

  int          cyc = 0, nfr = 0, done_cnt = 0, edge_cnt = 0, per_err = 0, dstab_err = 0;
  int          cur_len = 0, last_rise = -1;
  logic [63:0] cur_bits = 64'd0;
  bit          is_poll = 1'b0;
  logic        ncs_prev = 1'b1, co_prev = 1'b0, d_prev = 1'b0;
  int          fr_len[128], fr_start[128], fr_end[128];
  logic [63:0] fr_bits[128];

  always @(negedge clk) begin
    int          k;
    logic [7:0]  sb;
    cyc++;
    if (done_s === 1'b1) done_cnt++;
    if (co_s === 1'b1 && co_prev !== 1'b1) edge_cnt++;
    if (ncs_s === 1'b0 && ncs_prev !== 1'b0) begin
      fr_start[nfr] = cyc;
      cur_bits = 64'd0;
      cur_len = 0;
      last_rise = -1;
      is_poll = 1'b0;
    end
    if (ncs_s === 1'b0 && co_s === 1'b1 && co_prev !== 1'b1) begin
      cur_bits = {cur_bits[62:0], d_s};
      cur_len++;
      if (last_rise >= 0 && cyc - last_rise != 16) per_err++;
      last_rise = cyc;
      if (d_s !== d_prev) dstab_err++;
      if (cur_len == 8 && cur_bits[7:0] == 8'h05) is_poll = 1'b1;
    end
    if (ncs_s === 1'b0 && co_s === 1'b0 && co_prev === 1'b1 && is_poll) begin
      k = cur_len - 8;
      sb = stuck ? 8'hFF : ((k / 8) < wip_n ? 8'h01 : 8'h00);
      q_drv = sb[7 - (k % 8)];
    end
    if (ncs_s === 1'b1 && ncs_prev === 1'b0) begin
      fr_len[nfr] = cur_len;
      fr_bits[nfr] = cur_bits;
      fr_end[nfr] = cyc;
      if (nfr < 127) nfr++;
      is_poll = 1'b0;
    end
    ncs_prev = ncs_s;
    co_prev = co_s;
    d_prev = d_s;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input bit s, input int len);
    if (s) start4 = 1'b1; else start1 = 1'b1;
    repeat (len) @(negedge clk);
    start1 = 1'b0;
    start4 = 1'b0;
  endtask

  task automatic run_op(input bit s, input logic [23:0] a, input logic [31:0] dt,
                        input int wn, input bit stk, input bit dbl);
    int          base, dbase, nb, mb, limit, t;
    bit          exp_err;
    logic [63:0] exp_prog;
    sel = s;
    wip_n = wn;
    stuck = stk;
    @(negedge clk);
    base = nfr;
    dbase = done_cnt;
    addr_in = a;
    data1 = dt[7:0];
    data4 = dt;
    pulse_start(s, 3);
    check("busy_after_start", 64'(busy_s), 64'd1);
    check("error_cleared_on_start", 64'(err_s), 64'd0);
    if (dbl) begin
      t = 0;
      while (!(nfr == base + 1 && ncs_s === 1'b0 && cur_len >= 4) && t < 3000) begin
        @(negedge clk);
        t++;
      end
      check("reach_prog_for_second_edge", 64'(t < 3000), 64'd1);
      pulse_start(s, 2);
    end
    t = 0;
    while (done_cnt == dbase && t < 6000) begin
      @(negedge clk);
      t++;
    end
    check("done_within_budget", 64'(t < 6000), 64'd1);
    repeat (dbl ? 400 : 4) @(negedge clk);

    mb = s ? 4 : 1;
    limit = s ? 4 : 8191;
    if (stk || wn >= limit) begin
      nb = limit;
      exp_err = 1'b1;
    end else begin
      nb = wn + 1;
      exp_err = 1'b0;
    end
    exp_prog = s ? {8'h02, a, dt} : {24'h0, 8'h02, a, dt[7:0]};

    check("done_pulses", 64'(done_cnt - dbase), 64'd1);
    check("frame_count", 64'(nfr - base), 64'd3);
    check("wren_len", 64'(fr_len[base]), 64'd8);
    check("wren_bits", fr_bits[base], 64'h06);
    check("prog_len", 64'(fr_len[base+1]), 64'(32 + 8 * mb));
    check("prog_bits", fr_bits[base+1], exp_prog);
    check("poll_len", 64'(fr_len[base+2]), 64'(8 + 8 * nb));
    check("poll_bits", fr_bits[base+2], 64'h05 << (8 * nb));
    check("gap1_clks", 64'(fr_start[base+1] - fr_end[base]), 64'd32);
    check("gap2_clks", 64'(fr_start[base+2] - fr_end[base+1]), 64'd32);
    check("error_flag", 64'(err_s), 64'(exp_err));
    check("busy_idle", 64'(busy_s), 64'd0);
    check("ncs_idle", 64'(ncs_s), 64'd1);
  endtask

  initial begin
    int t, base, e0;

    // Start held high through reset must not launch an operation.
    start1 = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_ncs1", 64'(ncs1), 64'd1);
    check("rst_ncs4", 64'(ncs4), 64'd1);
    check("rst_busy1", 64'(busy1), 64'd0);
    check("rst_done1", 64'(done1), 64'd0);
    check("rst_err1", 64'(err1), 64'd0);
    check("rst_busy4", 64'(busy4), 64'd0);
    repeat (60) @(negedge clk);
    check("held_start_ignored", 64'(busy1), 64'd0);
    check("held_start_no_edges", 64'(edge_cnt), 64'd0);
    start1 = 1'b0;
    @(negedge clk);

    run_op(1'b0, 24'h012345, 32'h000000A5, 2, 1'b0, 1'b0);
    run_op(1'b1, 24'h00ABCD, 32'hDEADBEEF, 0, 1'b0, 1'b0);
    run_op(1'b1, 24'h1000FF, 32'h01234567, 0, 1'b1, 1'b0);
    run_op(1'b0, 24'h0A0B0C, 32'h0000003C, 1, 1'b0, 1'b1);

    // Abort in the middle of the address bytes.
    sel = 1'b0;
    wip_n = 0;
    stuck = 1'b0;
    base = nfr;
    addr_in = 24'hFEDCBA;
    data1 = 8'h5A;
    pulse_start(1'b0, 3);
    t = 0;
    while (!(nfr == base + 1 && ncs_s === 1'b0 && cur_len >= 14) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("reach_mid_address", 64'(t < 3000), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    check("abort_ncs", 64'(ncs1), 64'd1);
    check("abort_busy", 64'(busy1), 64'd0);
    e0 = edge_cnt;
    reset = 1'b0;
    repeat (200) @(negedge clk);
    check("abort_no_clk_edges", 64'(edge_cnt - e0), 64'd0);
    check("abort_ncs_stays", 64'(ncs1), 64'd1);
    run_op(1'b0, 24'h123456, 32'h000000C3, 0, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      run_op(1'($urandom_range(0, 1)), 24'($urandom), $urandom, int'($urandom_range(0, 5)), 1'b0, 1'b0);
    end

    check("clk_out_period_16", 64'(per_err), 64'd0);
    check("d_stable_at_rise", 64'(dstab_err), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
